// File: rtl/guess_round_ctrl.sv
// rtl/guess_round_ctrl.sv - windowed, restartable round sequencer for the guess-number game
//
// Ports:
//   clk, rst_n        rising-edge clock, synchronous active-low reset
//   start             level, begins a game when sampled in IDLE
//   next              level, closes the current answer window early
//   I1..I4            raw asynchronous player buttons (press = "yes")
//   A, B, C, D        per-player answer vectors, bit [r] = answer for round r
//   round_idx         current round number
//   busy              high while collecting or committing
//   round_done        one-cycle pulse in the cycle after each commit
//   done              one-cycle pulse in the cycle after the last commit

module guess_round_ctrl #(
    parameter int ROUNDS = 7,
    parameter int WINDOW = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              next,
    input  logic              I1,
    input  logic              I2,
    input  logic              I3,
    input  logic              I4,
    output logic [0:ROUNDS-1] A,
    output logic [0:ROUNDS-1] B,
    output logic [0:ROUNDS-1] C,
    output logic [0:ROUNDS-1] D,
    output logic [2:0]        round_idx,
    output logic              busy,
    output logic              round_done,
    output logic              done
);

    localparam int              CW       = $clog2(WINDOW) + 1;
    localparam logic [CW-1:0]   WIN_LOAD = CW'(WINDOW - 1);
    localparam logic [2:0]      LAST     = 3'(ROUNDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_COMMIT,
        ST_FINISH
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [CW-1:0]   win_cnt;
    logic [3:0]      flags;
    logic [3:0]      pins;
    logic [3:0]      sync1;
    logic [3:0]      sync2;
    logic [3:0]      prev;
    logic [3:0]      rise;
    logic            start_game;
    logic            accumulate;
    logic            commit_round;
    logic            last_round;

    assign pins       = {I4, I3, I2, I1};
    assign rise       = sync2 & ~prev;
    assign last_round = (round_idx == LAST);

    // Two synchroniser flops plus a previous-value flop; edges are produced
    // in every state and simply ignored outside COLLECT.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
        end else begin
            sync1 <= pins;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        busy         = 1'b0;
        done         = 1'b0;
        start_game   = 1'b0;
        accumulate   = 1'b0;
        commit_round = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    start_game = 1'b1;
                    state_next = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                busy       = 1'b1;
                accumulate = 1'b1;
                if (win_cnt == '0 || next) begin
                    state_next = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                busy         = 1'b1;
                commit_round = 1'b1;
                state_next   = last_round ? ST_FINISH : ST_COLLECT;
            end
            ST_FINISH: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            A          <= '0;
            B          <= '0;
            C          <= '0;
            D          <= '0;
            round_idx  <= '0;
            win_cnt    <= '0;
            flags      <= '0;
            round_done <= 1'b0;
        end else begin
            round_done <= commit_round;
            if (start_game) begin
                A         <= '0;
                B         <= '0;
                C         <= '0;
                D         <= '0;
                round_idx <= '0;
                win_cnt   <= WIN_LOAD;
                flags     <= '0;
            end
            // The counter may wrap on the exit cycle; it is reloaded before
            // the next window opens, so the wrapped value is never used.
            if (accumulate) begin
                flags   <= flags | rise;
                win_cnt <= win_cnt - CW'(1);
            end
            // Clearing flags here also discards any edge seen during COMMIT.
            if (commit_round) begin
                A[round_idx] <= flags[0];
                B[round_idx] <= flags[1];
                C[round_idx] <= flags[2];
                D[round_idx] <= flags[3];
                flags        <= '0;
                if (!last_round) begin
                    round_idx <= round_idx + 3'd1;
                    win_cnt   <= WIN_LOAD;
                end
            end
        end
    end

endmodule

// File: tb/tb_guess_round_ctrl.sv
// tb/tb_guess_round_ctrl.sv - self-checking bench for guess_round_ctrl

module tb_guess_round_ctrl;

    localparam int ROUNDS = 7;
    localparam int WINDOW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              nxt   = 1'b0;
    logic [3:0]        pins  = 4'b0;
    logic [0:ROUNDS-1] A, B, C, D;
    logic [2:0]        round_idx;
    logic              busy, round_done, done;

    guess_round_ctrl #(.ROUNDS(ROUNDS), .WINDOW(WINDOW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .next(nxt),
        .I1(pins[0]), .I2(pins[1]), .I3(pins[2]), .I4(pins[3]),
        .A(A), .B(B), .C(C), .D(D),
        .round_idx(round_idx), .busy(busy), .round_done(round_done), .done(done)
    );

    int total = 0;
    int bad   = 0;
    int done_seen = 0;

    // Reference model: pin history, game phase, cycles left in the window.
    logic [3:0]        h1 = '0, h2 = '0, h3 = '0;
    logic [3:0]        m_flags = '0;
    logic [0:ROUNDS-1] m_vec [4];
    int                m_phase = 0;   // 0 idle, 1 collecting, 2 committing, 3 finished
    int                m_round = 0;
    int                m_left  = 0;
    logic              m_rd = 1'b0, m_done = 1'b0;

    function automatic void model_step();
        logic [3:0] det;
        det = h2 & ~h3;   // pin high two edges ago, low three edges ago
        if (!rst_n) begin
            h1 = '0; h2 = '0; h3 = '0; m_flags = '0;
            for (int p = 0; p < 4; p++) m_vec[p] = '0;
            m_phase = 0; m_round = 0; m_left = 0; m_rd = 1'b0; m_done = 1'b0;
            return;
        end
        h3 = h2; h2 = h1; h1 = pins;
        m_rd = 1'b0; m_done = 1'b0;
        case (m_phase)
            0: if (start) begin
                for (int p = 0; p < 4; p++) m_vec[p] = '0;
                m_round = 0; m_left = WINDOW; m_flags = '0; m_phase = 1;
            end
            1: begin
                m_flags = m_flags | det;
                m_left--;
                if (m_left == 0 || nxt) m_phase = 2;
            end
            2: begin
                for (int p = 0; p < 4; p++) m_vec[p][m_round] = m_flags[p];
                m_flags = '0;
                m_rd = 1'b1;
                if (m_round == ROUNDS - 1) begin
                    m_phase = 3; m_done = 1'b1;
                end else begin
                    m_round++; m_left = WINDOW; m_phase = 1;
                end
            end
            default: m_phase = 0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        logic [33:0] got, exp;
        model_step();
        @(posedge clk);
        #1;
        if (done === 1'b1) done_seen++;
        got = {A, B, C, D, round_idx, busy, round_done, done};
        exp = {m_vec[0], m_vec[1], m_vec[2], m_vec[3], 3'(m_round),
               (m_phase == 1 || m_phase == 2), m_rd, m_done};
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL cycle t=%0t got A=%b B=%b C=%b D=%b ri=%0d busy=%b rd=%b done=%b want A=%b B=%b C=%b D=%b ri=%0d busy=%b rd=%b done=%b",
                     $time, A, B, C, D, round_idx, busy, round_done, done,
                     m_vec[0], m_vec[1], m_vec[2], m_vec[3], m_round,
                     exp[2], m_rd, m_done);
        end
    endtask

    typedef struct {
        bit                     use_next;
        logic [0:ROUNDS-1][3:0] press;   // bit0=I1 .. bit3=I4, per round
        logic [0:ROUNDS-1]      ea, eb, ec, ed;
    } game_t;

    game_t games [4];

    task automatic run_game(input game_t g, input int gi);
        int p, done_tick, rd_cnt, d0;
        p = g.use_next ? 3 : WINDOW + 1;
        done_tick = -1; rd_cnt = 0; d0 = done_seen;
        rst_n = 1'b1;
        for (int k = 0; k <= ROUNDS * p + 1; k++) begin
            start = (k == 0);
            pins  = 4'b0;
            nxt   = 1'b0;
            if (k % p == 0 && k / p < ROUNDS) pins = g.press[k / p];
            if (g.use_next && k % p == 2) nxt = 1'b1;
            tick();
            if (done === 1'b1) done_tick = k;
            if (round_done === 1'b1) rd_cnt++;
        end
        start = 1'b0;
        chk($sformatf("g%0d_A", gi), 32'(A), 32'(g.ea));
        chk($sformatf("g%0d_B", gi), 32'(B), 32'(g.eb));
        chk($sformatf("g%0d_C", gi), 32'(C), 32'(g.ec));
        chk($sformatf("g%0d_D", gi), 32'(D), 32'(g.ed));
        chk($sformatf("g%0d_done_tick", gi), 32'(done_tick), 32'(ROUNDS * p));
        chk($sformatf("g%0d_done_count", gi), 32'(done_seen - d0), 32'd1);
        chk($sformatf("g%0d_round_done_count", gi), 32'(rd_cnt), 32'(ROUNDS));
    endtask

    initial begin
        int d0;
        for (int p = 0; p < 4; p++) m_vec[p] = '0;

        games[0].use_next = 1'b0; games[0].press = '0;
        games[0].press[0] = 4'b0101; games[0].press[2] = 4'b0001; games[0].press[6] = 4'b1000;
        games[0].ea = 7'b1010000; games[0].eb = 7'b0000000;
        games[0].ec = 7'b1000000; games[0].ed = 7'b0000001;

        games[1].use_next = 1'b1; games[1].press = '0;
        games[1].press[1] = 4'b1111; games[1].press[5] = 4'b0010;
        games[1].ea = 7'b0100000; games[1].eb = 7'b0100010;
        games[1].ec = 7'b0100000; games[1].ed = 7'b0100000;

        games[2].use_next = 1'b0; games[2].press = '0;
        games[2].ea = '0; games[2].eb = '0; games[2].ec = '0; games[2].ed = '0;

        games[3].use_next = 1'b1; games[3].press = '0;
        games[3].press[0] = 4'b0010;
        games[3].ea = '0; games[3].eb = 7'b1000000; games[3].ec = '0; games[3].ed = '0;

        // Reset then idle.
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        d0 = done_seen;
        for (int k = 0; k < 10; k++) tick();
        chk("idle_vectors", 32'({A, B, C, D}), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_done_count", 32'(done_seen - d0), 32'd0);

        for (int i = 0; i < 4; i++) run_game(games[i], i);

        // Repeat presses, press on the last window cycle, press during COMMIT,
        // start pulsed while busy.
        for (int k = 0; k <= 64; k++) begin
            start = (k == 0) || (k >= 20 && k <= 22);
            pins  = (k == 9 || k == 11 || k == 13 || k == 33 || k == 43) ? 4'b0010 : 4'b0000;
            nxt   = 1'b0;
            tick();
            if (k == 22) chk("start_ignored_round", 32'(round_idx), 32'd2);
        end
        start = 1'b0; pins = 4'b0;
        chk("repeat_B", 32'(B), 32'(7'b0101000));
        chk("repeat_ACD", 32'({A, C, D}), 32'd0);
        for (int k = 0; k < 10; k++) tick();
        chk("hold_B", 32'(B), 32'(7'b0101000));
        chk("hold_round_idx", 32'(round_idx), 32'(ROUNDS - 1));

        // New game clears the held vectors, then abort by reset in round 4.
        d0 = done_seen;
        for (int k = 0; k <= 40; k++) begin
            start = (k == 0);
            pins  = (k == 0 || k == 18) ? 4'b0001 : 4'b0000;
            rst_n = !(k == 39 || k == 40);
            tick();
            if (k == 0) chk("restart_clears_B", 32'(B), 32'd0);
            if (k == 38) chk("abort_partial_A", 32'(A), 32'(7'b1010000));
        end
        rst_n = 1'b1; start = 1'b0; pins = 4'b0;
        chk("abort_vectors", 32'({A, B, C, D}), 32'd0);
        chk("abort_state", 32'({round_idx, busy, round_done, done}), 32'd0);
        for (int k = 0; k < 3; k++) tick();
        chk("abort_no_done", 32'(done_seen - d0), 32'd0);
        run_game(games[3], 4);

        // start and next held high: each round is 1 COLLECT + 1 COMMIT,
        // and the game restarts straight out of DONE.
        d0 = done_seen;
        start = 1'b1; nxt = 1'b1;
        for (int k = 0; k <= 16; k++) begin
            tick();
            if (k == 14) chk("held_done_tick", 32'(done), 32'd1);
        end
        chk("held_restart_busy", 32'(busy), 32'd1);
        chk("held_done_count", 32'(done_seen - d0), 32'd1);
        start = 1'b0; nxt = 1'b0;

        // Randomised traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            rst_n = ($urandom_range(0, 199) != 0);
            start = ($urandom_range(0, 7) == 0);
            nxt   = ($urandom_range(0, 5) == 0);
            for (int p = 0; p < 4; p++) pins[p] = ($urandom_range(0, 2) == 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/guess_round_ctrl.md
Name: guess_round_ctrl

Overview:
- Sequences one game of the guess-number datapath.
- Runs ROUNDS answer rounds. In each round, up to four players (I1..I4) press once for "yes"; no press means "no".
- Commits each round's answers into bit [round] of the per-player vectors A..D, then flags game completion.
- Replaces the free-running edge-triggered capture with a clocked, windowed, restartable controller. Sits between the synchronised button inputs and the number-decode/display logic.

Parameters:
- ROUNDS, 7, number of rounds; also the width of A..D, indexed [0:ROUNDS-1], with bit 0 = round 0.
- WINDOW, 1024, clock cycles per answer window (legal range is 1 or more).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  level; sampled in IDLE only.
- next  input  1  level; ends the current window early (sampled in COLLECT only).
- I1, I2, I3, I4  input  1 each  raw player buttons, asynchronous levels.
- A, B, C, D  output  ROUNDS each  [0:ROUNDS-1] per-player answer vectors.
- round_idx  output  3  current round number.
- busy  output  1  high in COLLECT and COMMIT.
- round_done  output  1  one-cycle pulse after each commit.
- done  output  1  one-cycle pulse after the last commit.

Behaviour:
- Reset: clk/rst_n is the only clock/reset. When rst_n=0 at a clk edge:
  - state=IDLE; A..D=0; round_idx=0; busy=0; round_done=0; done=0.
  - Sync flops, edge registers and flags all cleared.
  - This applies mid-game: the game is aborted with no done pulse.
- Input conditioning: each Ix passes through a 2-flop synchroniser plus a previous-value register.
  - A rising edge is detected as (sync=1, prev=0).
  - Latency from pin to detected edge is 3 clk edges.
  - Edges are detected in every state but acted on only in COLLECT.
- IDLE:
  - busy=0; A..D hold their last values.
  - start=1 → clear A..D to 0, round_idx=0, win_cnt=WINDOW-1, flags=0, go to COLLECT.
- COLLECT:
  - A detected edge on player k sets flag[k] (sticky; repeat presses have no effect).
  - win_cnt decrements each cycle.
  - Exit to COMMIT when win_cnt==0 or next=1.
  - An edge detected in the exit cycle is still counted.
  - start is ignored.
- COMMIT (exactly 1 cycle):
  - A[round_idx]=flag[0], B=flag[1], C=flag[2], D=flag[3]; flags cleared.
  - Edges detected in COMMIT are dropped.
  - If round_idx==ROUNDS-1 → DONE.
  - Otherwise round_idx+1, win_cnt=WINDOW-1 → COLLECT.
  - round_done=1 in the cycle following COMMIT. Vectors are already updated in that cycle; round_idx already shows the next round, or holds ROUNDS-1 on the last round.
- DONE (1 cycle): done=1 (coincident with the final round_done), busy=0 → IDLE.
  - Vectors and round_idx are held until the next start.
- Round length: with no next, each round occupies WINDOW COLLECT cycles plus 1 COMMIT cycle.
- Simultaneous events:
  - Several players pressing in the same cycle all register.
  - next together with an edge in the same cycle: the edge counts.
  - start held high through DONE→IDLE immediately starts a new game in the IDLE cycle.
- Only A..D, round_idx, busy, round_done and done are visible; win_cnt width is clog2(WINDOW)+1 and is internal.

Test Plan:
- Reset/idle: rst_n=0 for 2 cycles, then idle 10 cycles → A..D=0, busy=0, done never asserts.
- Basic game (WINDOW=8): start; in round 0 pulse I1 and I3; in round 2 pulse I1; in round 6 pulse I4; no other presses → after 7×9 cycles done pulses once with A=1010000, B=0000000, C=1000000, D=0000001 (left-most = round 0); round_done pulses 7 times.
- Repeat and timing (WINDOW=8): in round 1, press I2 three times; in round 3, press I2 at the last COLLECT cycle (edge detected on win_cnt==0) → B=0101000. A second I2 edge landing in COMMIT is not counted.
- Early advance: assert next 2 cycles after each round starts → each round lasts 3 cycles (2 COLLECT + 1 COMMIT); done at 21 cycles after leaving IDLE.
- Abort and restart: rst_n=0 during round 4 with A partly set → all outputs 0, no done. Then start a new game with only I2 pressed in round 0 → B=1000000, A=C=D=0.
- start ignored while busy; vectors hold after done until the next start clears them.
